// File: rtl/sdspi_rx_deserializer_pkg.sv
// Shared constants for the SD-SPI receive deserializer: FSM encodings and the start-token level.
package sdspi_rx_deserializer_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_TOKEN = 2'd1;
  localparam logic [1:0] ST_SHIFT      = 2'd2;

  localparam logic SD_START_TOKEN_BIT = 1'b0;

  // Smallest counter width able to hold 0..n-1, never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdspi_rx_deserializer_sipo_shift.sv
// Serial-in/parallel-out shifter. q_next is the word as it will look after the next enabled
// shift, so the caller can capture a completed word in the same cycle as its final bit.
module sipo_shift #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] q_q;

  generate
    if (WIDTH == 1) begin : g_single
      assign q_next = d;
    end else if (MSB_FIRST) begin : g_msb
      assign q_next = {q_q[WIDTH-2:0], d};
    end else begin : g_lsb
      assign q_next = {d, q_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= q_next;
    end
  end

endmodule

// File: rtl/sdspi_rx_deserializer.sv
// SD-SPI receive deserializer: waits for the start token, assembles WIDTH-bit words from MISO
// and drives clear/write strobes to the downstream register.
module sdspi_rx_deserializer
  import sdspi_rx_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      nwords,
  input  logic             abort,
  input  logic             sclk_rise,
  input  logic             miso,
  output logic             cl,
  output logic             w,
  output logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      word_idx
);

  localparam int unsigned TW = cnt_width(TIMEOUT);
  localparam int unsigned BW = cnt_width(WIDTH);

  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [15:0]      nwords_q, nwords_d;
  logic [15:0]      word_idx_q, word_idx_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             cl_q, cl_d;
  logic             w_q, w_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             shift_en;
  logic             shift_clr;
  logic [WIDTH-1:0] shift_next;

  sipo_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sipo (
    .clk    (clk),
    .rst    (rst),
    .en     (shift_en),
    .clr    (shift_clr),
    .d      (miso),
    .q_next (shift_next)
  );

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    nwords_d   = nwords_q;
    word_idx_d = word_idx_q;
    din_d      = din_q;
    busy_d     = busy_q;
    err_d      = err_q;
    cl_d       = 1'b0;
    w_d        = 1'b0;
    done_d     = 1'b0;
    shift_en   = 1'b0;
    shift_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (nwords == 16'd0) begin
            done_d = 1'b1;
          end else begin
            nwords_d   = nwords;
            cl_d       = 1'b1;
            busy_d     = 1'b1;
            word_idx_d = 16'd0;
            tcnt_d     = '0;
            bcnt_d     = '0;
            shift_clr  = 1'b1;
            state_d    = ST_WAIT_TOKEN;
          end
        end
      end

      ST_WAIT_TOKEN: begin
        if (abort) begin
          done_d    = 1'b1;
          err_d     = 1'b1;
          busy_d    = 1'b0;
          shift_clr = 1'b1;
          state_d   = ST_IDLE;
        end else if (sclk_rise) begin
          if (miso == SD_START_TOKEN_BIT) begin
            bcnt_d  = '0;
            state_d = ST_SHIFT;
          end else if (tcnt_q == TCNT_LAST) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        // Abort wins over a coincident strobe, so the partial word never reaches din.
        if (abort) begin
          done_d    = 1'b1;
          err_d     = 1'b1;
          busy_d    = 1'b0;
          shift_clr = 1'b1;
          state_d   = ST_IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bcnt_q == BCNT_LAST) begin
            w_d        = 1'b1;
            din_d      = shift_next;
            word_idx_d = word_idx_q + 16'd1;
            bcnt_d     = '0;
            if (word_idx_q + 16'd1 == nwords_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      nwords_q   <= '0;
      word_idx_q <= '0;
      din_q      <= '0;
      cl_q       <= 1'b0;
      w_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      nwords_q   <= nwords_d;
      word_idx_q <= word_idx_d;
      din_q      <= din_d;
      cl_q       <= cl_d;
      w_q        <= w_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cl       = cl_q;
  assign w        = w_q;
  assign din      = din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign word_idx = word_idx_q;

endmodule

// File: tb/tb_sdspi_rx_deserializer.sv
// Directed bench for sdspi_rx_deserializer: an MSB-first and an LSB-first instance share stimulus.
module tb_sdspi_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] nwords = 16'd0;
  logic        abort = 1'b0;
  logic        sclk_rise = 1'b0;
  logic        miso = 1'b1;

  logic        cl, w, busy, done, err;
  logic [7:0]  din;
  logic [15:0] word_idx;

  logic        cl_l, w_l, busy_l, done_l, err_l;
  logic [7:0]  din_l;
  logic [15:0] word_idx_l;

  int checks = 0;
  int errors = 0;

  int cl_cnt, w_cnt, done_cnt, w_l_cnt, clw_both;
  logic done_err, done_with_w;
  logic [7:0] wlog [$];

  always #5 clk = ~clk;

  sdspi_rx_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .nwords(nwords), .abort(abort),
    .sclk_rise(sclk_rise), .miso(miso), .cl(cl), .w(w), .din(din), .busy(busy),
    .done(done), .err(err), .word_idx(word_idx)
  );

  sdspi_rx_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT(16)) dut_l (
    .clk(clk), .rst(rst), .start(start), .nwords(nwords), .abort(abort),
    .sclk_rise(sclk_rise), .miso(miso), .cl(cl_l), .w(w_l), .din(din_l), .busy(busy_l),
    .done(done_l), .err(err_l), .word_idx(word_idx_l)
  );

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (cl) cl_cnt++;
    if (cl && w) clw_both++;
    if (w) begin
      w_cnt++;
      wlog.push_back(din);
    end
    if (w_l) w_l_cnt++;
    if (done) begin
      done_cnt++;
      done_err = err;
      done_with_w = w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cl_cnt = 0; w_cnt = 0; done_cnt = 0; w_l_cnt = 0; clw_both = 0;
    done_err = 1'bx; done_with_w = 1'bx;
    wlog.delete();
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    nwords = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    miso = b;
    sclk_rise = 1'b1;
    @(negedge clk);
    sclk_rise = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte_msb(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  initial begin
    clear_mon();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_outs", {cl, w, busy, done, err}, 5'b0);
    chk("rst_din", din, 8'h00);
    chk("rst_widx", word_idx, 16'd0);

    // 1: two-word frame after two idle-high samples
    clear_mon();
    do_start(16'd2);
    chk("t1_busy", busy, 1'b1);
    chk("t1_cl_now", cl, 1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_byte_msb(8'hA5);
    chk("t1_widx1", word_idx, 16'd1);
    send_byte_msb(8'h3C);
    chk("t1_cl_cnt", cl_cnt, 1);
    chk("t1_w_cnt", w_cnt, 2);
    chk("t1_word0", wlog[0], 8'hA5);
    chk("t1_word1", wlog[1], 8'h3C);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_w", done_with_w, 1'b1);
    chk("t1_done_err", done_err, 1'b0);
    chk("t1_widx2", word_idx, 16'd2);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_din_hold", din, 8'h3C);
    chk("t1_clw", clw_both, 0);

    // 2: token timeout with TIMEOUT=16
    clear_mon();
    do_start(16'd1);
    for (int i = 0; i < 15; i++) send_bit(1'b1);
    chk("t2_no_done_15", done_cnt, 0);
    chk("t2_busy_15", busy, 1'b1);
    send_bit(1'b1);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_err", err, 1'b1);
    chk("t2_done_err", done_err, 1'b1);
    chk("t2_w_cnt", w_cnt, 0);
    chk("t2_busy", busy, 1'b0);

    // 3: empty frame
    clear_mon();
    do_start(16'd0);
    chk("t3_done_now", done, 1'b1);
    chk("t3_err_clr", err, 1'b0);
    chk("t3_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("t3_cl_cnt", cl_cnt, 0);
    chk("t3_w_cnt", w_cnt, 0);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_busy_after", busy, 1'b0);

    // 4: LSB-first ordering
    clear_mon();
    do_start(16'd1);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t4_lsb_w", w_l_cnt, 1);
    chk("t4_lsb_din", din_l, 8'hA5);
    chk("t4_lsb_done", done_l, 1'b0);
    chk("t4_msb_din", din, 8'hA5);

    // 5: asynchronous reset mid-word
    clear_mon();
    do_start(16'd1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", {cl, w, busy, done, err}, 5'b0);
    chk("t5_rst_din", din, 8'h00);
    chk("t5_rst_widx", word_idx, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    do_start(16'd1);
    send_bit(1'b0);
    send_byte_msb(8'h5A);
    chk("t5_w_cnt", w_cnt, 1);
    chk("t5_din", din, 8'h5A);
    chk("t5_done", done_cnt, 1);

    // 6: abort with coincident strobe, idle abort, start while busy
    clear_mon();
    do_start(16'd1);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    abort = 1'b1; miso = 1'b1; sclk_rise = 1'b1;
    @(negedge clk);
    abort = 1'b0; sclk_rise = 1'b0;
    chk("t6_done", done, 1'b1);
    chk("t6_err", err, 1'b1);
    chk("t6_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_w_cnt", w_cnt, 0);
    chk("t6_din_kept", din, 8'h5A);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("t6_idle_abort", done_cnt, 1);

    clear_mon();
    do_start(16'd2);
    send_bit(1'b0);
    send_byte_msb(8'hC3);
    chk("t6_widx1", word_idx, 16'd1);
    do_start(16'd1);
    chk("t6_ignored_widx", word_idx, 16'd1);
    chk("t6_ignored_busy", busy, 1'b1);
    chk("t6_ignored_cl", cl_cnt, 1);
    send_byte_msb(8'h81);
    chk("t6_w2_cnt", w_cnt, 2);
    chk("t6_word1", wlog[1], 8'h81);
    chk("t6_widx2", word_idx, 16'd2);
    chk("t6_done2", done_cnt, 1);
    chk("t6_err2", done_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
